// File: rtl/mul_div_unit.sv
// Iterative signed multiply / divide unit.
// Multiply uses radix-2 Booth recoding over a {acc, q, q_m1} shift register.
// Divide runs restoring division on operand magnitudes and fixes signs in FIX.
// ITER is expected to equal DATA_WIDTH; one operand bit is consumed per CALC edge.
module mul_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ITER       = DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(ITER) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic          r_op;
  logic [W-1:0]  r_a, r_b;       // captured operands, kept for sign fix-up and div-by-zero
  logic [W:0]    r_acc;          // Booth partial product / division remainder (one guard bit)
  logic [W-1:0]  r_q;            // multiplier bits / dividend-then-quotient bits
  logic          r_q_m1;         // Booth appended bit
  logic [W:0]    r_m;            // sign-extended multiplicand or divisor magnitude
  logic [W-1:0]  r_hi, r_lo;
  logic          r_dbz;

  logic [W-1:0]  w_a_abs, w_b_abs;
  logic [W:0]    w_sum, w_shift, w_diff;
  logic [W:0]    w_acc_next;
  logic [W-1:0]  w_q_next;
  logic          w_q_m1_next;
  logic [W-1:0]  w_fix_hi, w_fix_lo;
  logic          w_fix_dbz;
  logic          w_last;

  assign w_a_abs = a[W-1] ? (~a + 1'b1) : a;
  assign w_b_abs = b[W-1] ? (~b + 1'b1) : b;
  assign w_last  = (r_cnt == CW'(ITER - 1));

  assign busy        = (r_state == S_CALC) || (r_state == S_FIX);
  assign done        = (r_state == S_DONE);
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

  // Next-state logic: start only matters in IDLE, DONE always returns to IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CALC;
      S_CALC:  if (w_last) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // One iteration step: Booth add/sub + arithmetic shift, or restoring divide step
  always_comb begin
    w_sum       = r_acc;
    w_shift     = {r_acc[W-1:0], r_q[W-1]};
    w_diff      = w_shift - r_m;
    w_acc_next  = r_acc;
    w_q_next    = r_q;
    w_q_m1_next = 1'b0;
    if (!r_op) begin
      case ({r_q[0], r_q_m1})
        2'b01:   w_sum = r_acc + r_m;
        2'b10:   w_sum = r_acc - r_m;
        default: w_sum = r_acc;
      endcase
      w_acc_next  = {w_sum[W], w_sum[W:1]};
      w_q_next    = {w_sum[0], r_q[W-1:1]};
      w_q_m1_next = r_q[0];
    end else if (!w_diff[W]) begin
      w_acc_next = w_diff;
      w_q_next   = {r_q[W-2:0], 1'b1};
    end else begin
      w_acc_next = w_shift;
      w_q_next   = {r_q[W-2:0], 1'b0};
    end
  end

  // Result formation: product passes through, divide gets sign correction or div-by-zero values
  always_comb begin
    w_fix_hi  = r_acc[W-1:0];
    w_fix_lo  = r_q;
    w_fix_dbz = 1'b0;
    if (r_op) begin
      if (r_b == '0) begin
        w_fix_hi  = r_a;
        w_fix_lo  = '1;
        w_fix_dbz = 1'b1;
      end else begin
        w_fix_lo = (r_a[W-1] ^ r_b[W-1]) ? (~r_q + 1'b1) : r_q;
        w_fix_hi = r_a[W-1] ? (~r_acc[W-1:0] + 1'b1) : r_acc[W-1:0];
      end
    end
  end

  // Datapath: capture in IDLE, iterate in CALC, publish results on the FIX->DONE edge
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_cnt  <= '0;
      r_op   <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_q_m1 <= 1'b0;
      r_m    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_dbz  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt  <= '0;
            r_op   <= op;
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_q_m1 <= 1'b0;
            if (!op) begin
              r_q <= b;
              r_m <= {a[W-1], a};
            end else begin
              r_q <= w_a_abs;
              r_m <= {1'b0, w_b_abs};
            end
          end
        end
        S_CALC: begin
          r_cnt  <= r_cnt + 1'b1;
          r_acc  <= w_acc_next;
          r_q    <= w_q_next;
          r_q_m1 <= w_q_m1_next;
        end
        S_FIX: begin
          r_hi  <= w_fix_hi;
          r_lo  <= w_fix_lo;
          r_dbz <= w_fix_dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit with hand-computed expected results.
module tb_mul_div_unit;

  logic        clock;
  logic        clear;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic        div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  mul_div_unit #(.DATA_WIDTH(32), .ITER(32)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Launch one operation, scramble inputs after capture, then check latency and result.
  task automatic run_op(input string tag, input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int  n;
    bit  seen;
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = ~o;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (done) seen = 1;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(ehi));
    check({tag, "_lo"}, 64'(lo), 64'(elo));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d after %0d edges", o, av, bv, hi, lo, div_by_zero, n);
    @(posedge clock); #1;
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n_done;
    logic [31:0] first_hi, first_lo;

    clear = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;

    run_op("mul_7x-3",  1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("mul_minsq", 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run_op("mul_maxneg1", 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0);
    run_op("div_-7/2",  1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_7/-2",  1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_op("div_5/0",   1'b1, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    check("hold_hi", 64'(hi), 64'h5);
    check("hold_dbz", 64'(div_by_zero), 64'd1);
    run_op("mul_3x4",   1'b0, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0);
    run_op("div_min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("div_100/-7", 1'b1, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 1'b0);

    // Restart attempt while busy: 100/7 must complete untouched, with one done.
    op = 1'b1; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    start = 1'b1; op = 1'b0; a = 32'h0000FFFF; b = 32'h00000001;
    @(posedge clock); #1;
    start = 1'b0;
    n_done = 0; first_hi = '0; first_lo = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (done) begin
        if (n_done == 0) begin first_hi = hi; first_lo = lo; end
        n_done++;
      end
    end
    check("restart_ndone", 64'(n_done), 64'd1);
    check("restart_hi", 64'(first_hi), 64'd2);
    check("restart_lo", 64'(first_lo), 64'd14);
    $display("restart-during-busy: dones=%0d hi=%h lo=%h", n_done, first_hi, first_lo);

    // Abort with clear mid-operation.
    op = 1'b0; a = 32'h00000009; b = 32'h00000009; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    check("pre_clear_busy", 64'(busy), 64'd1);
    clear = 1'b0;
    #1;
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    check("clr_hi", 64'(hi), 64'd0);
    check("clr_lo", 64'(lo), 64'd0);
    check("clr_dbz", 64'(div_by_zero), 64'd0);
    @(posedge clock); #1;
    clear = 1'b1;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (done) n_done++;
    end
    check("clr_no_done", 64'(n_done), 64'd0);
    $display("clear abort: dones in 40 cycles=%0d", n_done);

    run_op("mul_after_clr", 1'b0, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result half-width; all widths below scale with it.
REQ-002 Parameter ITER, default DATA_WIDTH, number of iteration cycles in CALC.
REQ-003 Port clock, input, 1, single clock; all state changes on its rising edge.
REQ-004 Port clear, input, 1, asynchronous active-low reset.
REQ-005 Port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-006 Port op, input, 1, operation select: 0 = signed multiply, 1 = signed divide.
REQ-007 Port a, input, DATA_WIDTH, multiplicand or dividend (driven from the Y register).
REQ-008 Port b, input, DATA_WIDTH, multiplier or divisor (driven from the bus).
REQ-009 Port busy, output, 1, high in states CALC and FIX.
REQ-010 Port done, output, 1, one-cycle pulse marking hi/lo/div_by_zero valid; feeds ZHI/ZLO register enables.
REQ-011 Port hi, output, DATA_WIDTH, product upper half or remainder.
REQ-012 Port lo, output, DATA_WIDTH, product lower half or quotient.
REQ-013 Port div_by_zero, output, 1, set with done when op=1 and b=0.

Function
REQ-014 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-015 IDLE->CALC on an edge with start=1; a, b and op are captured at that edge, and the iteration counter is cleared to 0.
REQ-016 CALC SHALL perform one iteration per edge for ITER edges; on the edge where counter = ITER-1, CALC->FIX.
REQ-017 FIX SHALL apply sign correction, then FIX->DONE on the next edge, writing hi/lo/div_by_zero at that edge.
REQ-018 DONE SHALL last exactly one cycle, with done=1; DONE->IDLE unconditionally.
REQ-019 Latency: done SHALL be high in the cycle following the (ITER+1)th edge after the start-sampling edge, i.e. 33 edges for the default.
REQ-020 start SHALL be ignored in CALC, FIX and DONE; no queuing.
REQ-021 Changes on a, b or op after capture SHALL NOT affect the result.
REQ-022 Multiply SHALL use radix-2 Booth recoding and give {hi,lo} = exact 2*DATA_WIDTH-bit two's-complement product of a*b.
REQ-023 Divide SHALL give lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign, with a = lo*b + hi.
REQ-024 Divide with b=0 SHALL keep the same latency and produce hi=a, lo=all ones, and div_by_zero=1.
REQ-025 Divide of the most-negative value by -1 SHALL wrap to lo=most-negative and hi=0, with no flag.
REQ-026 hi, lo and div_by_zero SHALL hold their values from one DONE until the next DONE.
REQ-027 div_by_zero SHALL be 0 for any multiply and for divides with nonzero b.

Reset
REQ-028 clear=0 SHALL immediately force: state IDLE, counter 0, busy=0, done=0, hi=0, lo=0, div_by_zero=0, and all internal operand/accumulator registers 0.
REQ-029 clear asserted mid-operation SHALL abort that operation, with no later done pulse.
REQ-030 After clear returns high, the first edge with start=1 SHALL begin a new operation normally.

Verification
REQ-031 Multiply 7 x -3 (a=00000007, b=FFFFFFFD, op=0) -> 33 edges later done=1 for one cycle, with hi=FFFFFFFF, lo=FFFFFFEB, busy low in the done cycle.
REQ-032 Multiply 80000000 x 80000000 -> hi=40000000, lo=00000000; then 7FFFFFFF x FFFFFFFF -> hi=FFFFFFFF, lo=80000001.
REQ-033 Divide -7/2 (a=FFFFFFF9, b=00000002, op=1) -> lo=FFFFFFFD, hi=FFFFFFFF; then 7/-2 -> lo=FFFFFFFD, hi=00000001.
REQ-034 Divide 5/0 -> done after 33 edges with div_by_zero=1, hi=00000005, lo=FFFFFFFF; a following multiply clears div_by_zero.
REQ-035 Divide 80000000/FFFFFFFF -> lo=80000000, hi=00000000, div_by_zero=0.
REQ-036 Pulse start again at cycle 10 of a busy operation, and change a/b -> first result unaffected and exactly one done; then pull clear low at cycle 15 of a new operation -> outputs 0 at once and no done within 40 cycles.
